// File: rtl/pix_reduce_if.sv
// Pixel stream bus for pix_reduce: input beat with position/address, output beat,
// and the valid/ready handshakes on both sides.
interface pix_reduce_if #(
    parameter int PIX_PER_WORD = 2,
    parameter int CH_W         = 6,
    parameter int ADDR_W       = 19
);
    localparam int PW = PIX_PER_WORD * 3 * CH_W;

    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic [PW-1:0]     pix_in;
    logic [ADDR_W-1:0] write_addr;
    logic              in_valid;
    logic              in_ready;
    logic [PW-1:0]     pix_out;
    logic [ADDR_W-1:0] pix_addr;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output hcount, vcount, pix_in, write_addr, in_valid, out_ready,
        input  in_ready, pix_out, pix_addr, out_valid
    );

    modport slave (
        input  hcount, vcount, pix_in, write_addr, in_valid, out_ready,
        output in_ready, pix_out, pix_addr, out_valid
    );
endinterface

// File: rtl/pix_reduce.sv
// Colour-depth reduction stage (truncate / round / 4x4 ordered dither / passthrough)
// as a two-stage valid/ready pipeline; config changes wait until the pipeline drains.
module pix_reduce #(
    parameter int PIX_PER_WORD = 2,
    parameter int CH_W         = 6,
    parameter int ADDR_W       = 19,
    localparam int KW          = $clog2(CH_W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    pix_reduce_if.slave   bus,
    input  logic [1:0]    cfg_mode,
    input  logic [KW-1:0] cfg_keep_r,
    input  logic [KW-1:0] cfg_keep_g,
    input  logic [KW-1:0] cfg_keep_b,
    input  logic          cfg_update
);
    localparam int PW = PIX_PER_WORD * 3 * CH_W;

    typedef logic [CH_W:0] ext_t;

    logic [1:0]        mode_q, p_mode_q;
    logic [KW-1:0]     keep_r_q, keep_g_q, keep_b_q;
    logic [KW-1:0]     p_keep_r_q, p_keep_g_q, p_keep_b_q;
    logic              pend_q, pend_d;
    logic              init_q;
    logic              s1_v_q, s1_v_d;
    logic [PW-1:0]     s1_pix_q, s1_pix_d;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              s2_v_q, s2_v_d;
    logic [PW-1:0]     s2_pix_q, s2_pix_d;
    logic [ADDR_W-1:0] s2_addr_q;

    logic              s2_load_s, s1_adv_s, in_ready_s, accept_s, apply_s;
    logic [KW-1:0]     drop_s [3];

    function automatic logic [KW-1:0] drop_of(input logic [KW-1:0] k);
        logic [KW-1:0] kc;
        if (k == '0) begin
            kc = KW'(1);
        end else if (k > KW'(CH_W)) begin
            kc = KW'(CH_W);
        end else begin
            kc = k;
        end
        return KW'(CH_W) - kc;
    endfunction

    function automatic logic [3:0] bayer(input logic [10:0] hc, input logic [1:0] vc, input int p);
        logic [12:0] x;
        logic [3:0]  t;
        x = 13'(hc) * 13'(PIX_PER_WORD) + 13'(p);
        case ({vc, x[1:0]})
            4'd0:    t = 4'd0;
            4'd1:    t = 4'd8;
            4'd2:    t = 4'd2;
            4'd3:    t = 4'd10;
            4'd4:    t = 4'd12;
            4'd5:    t = 4'd4;
            4'd6:    t = 4'd14;
            4'd7:    t = 4'd6;
            4'd8:    t = 4'd3;
            4'd9:    t = 4'd11;
            4'd10:   t = 4'd1;
            4'd11:   t = 4'd9;
            4'd12:   t = 4'd15;
            4'd13:   t = 4'd7;
            4'd14:   t = 4'd13;
            4'd15:   t = 4'd5;
            default: t = 4'd0;
        endcase
        return t;
    endfunction

    // Round adds half an LSB of the kept depth; dither scales the 0..15 threshold to d bits.
    function automatic ext_t calc_offset(input logic [1:0] mode, input logic [KW-1:0] d,
                                         input logic [3:0] t);
        ext_t off;
        off = '0;
        case (mode)
            2'd1: begin
                if (d != '0) begin
                    off = ext_t'(1) << (d - KW'(1));
                end else begin
                    off = '0;
                end
            end
            2'd2: begin
                if (d <= KW'(4)) begin
                    off = ext_t'(t) >> (KW'(4) - d);
                end else begin
                    off = ext_t'(t) << (d - KW'(4));
                end
            end
            default: off = '0;
        endcase
        return off;
    endfunction

    function automatic logic [CH_W-1:0] add_sat(input logic [CH_W-1:0] v, input ext_t off);
        ext_t s;
        s = ext_t'(v) + off;
        if (s[CH_W]) begin
            return '1;
        end else begin
            return s[CH_W-1:0];
        end
    endfunction

    function automatic logic [CH_W-1:0] mask_ch(input logic [CH_W-1:0] v, input logic [1:0] mode,
                                                 input logic [KW-1:0] d);
        logic [CH_W-1:0] r;
        r = v;
        if (mode != 2'd3) begin
            for (int b = 0; b < CH_W; b++) begin
                if (b < int'(d)) begin
                    r[b] = 1'b0;
                end else begin
                    r[b] = v[b];
                end
            end
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Drop counts per channel; index 0 is B (lowest field), 2 is R.
    always_comb begin
        drop_s[0] = drop_of(keep_b_q);
        drop_s[1] = drop_of(keep_g_q);
        drop_s[2] = drop_of(keep_r_q);
    end

    // Handshake and stage-occupancy next state.
    always_comb begin
        s2_load_s  = !s2_v_q || bus.out_ready;
        s1_adv_s   = s1_v_q && s2_load_s;
        in_ready_s = init_q && !pend_q && (!s1_v_q || s1_adv_s);
        accept_s   = bus.in_valid && in_ready_s;
        apply_s    = pend_q && !s1_v_q && !s2_v_q;

        if (accept_s) begin
            s1_v_d = 1'b1;
        end else if (s1_adv_s) begin
            s1_v_d = 1'b0;
        end else begin
            s1_v_d = s1_v_q;
        end

        if (s2_load_s) begin
            s2_v_d = s1_v_q;
        end else begin
            s2_v_d = s2_v_q;
        end

        if (cfg_update) begin
            pend_d = 1'b1;
        end else if (apply_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Stage 1 datapath: offset add with saturation.
    always_comb begin
        s1_pix_d = '0;
        for (int p = 0; p < PIX_PER_WORD; p++) begin
            for (int j = 0; j < 3; j++) begin
                s1_pix_d[(p*3+j)*CH_W +: CH_W] =
                    add_sat(bus.pix_in[(p*3+j)*CH_W +: CH_W],
                            calc_offset(mode_q, drop_s[j], bayer(bus.hcount, bus.vcount[1:0], p)));
            end
        end
    end

    // Stage 2 datapath: clear the dropped LSBs.
    always_comb begin
        s2_pix_d = '0;
        for (int c = 0; c < PIX_PER_WORD * 3; c++) begin
            s2_pix_d[c*CH_W +: CH_W] = mask_ch(s1_pix_q[c*CH_W +: CH_W], mode_q, drop_s[c % 3]);
        end
    end

    // Config, pipeline and handshake state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q     <= 2'd0;
            keep_r_q   <= KW'(2);
            keep_g_q   <= KW'(3);
            keep_b_q   <= KW'(2);
            p_mode_q   <= 2'd0;
            p_keep_r_q <= KW'(2);
            p_keep_g_q <= KW'(3);
            p_keep_b_q <= KW'(2);
            pend_q     <= 1'b0;
            init_q     <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_pix_q   <= '0;
            s1_addr_q  <= '0;
            s2_v_q     <= 1'b0;
            s2_pix_q   <= '0;
            s2_addr_q  <= '0;
        end else begin
            init_q <= 1'b1;
            pend_q <= pend_d;
            if (cfg_update) begin
                p_mode_q   <= cfg_mode;
                p_keep_r_q <= cfg_keep_r;
                p_keep_g_q <= cfg_keep_g;
                p_keep_b_q <= cfg_keep_b;
            end
            if (apply_s) begin
                mode_q   <= p_mode_q;
                keep_r_q <= p_keep_r_q;
                keep_g_q <= p_keep_g_q;
                keep_b_q <= p_keep_b_q;
            end
            s1_v_q <= s1_v_d;
            if (accept_s) begin
                s1_pix_q  <= s1_pix_d;
                s1_addr_q <= bus.write_addr;
            end
            s2_v_q <= s2_v_d;
            if (s2_load_s && s1_v_q) begin
                s2_pix_q  <= s2_pix_d;
                s2_addr_q <= s1_addr_q;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_v_q;
    assign bus.pix_out   = s2_pix_q;
    assign bus.pix_addr  = s2_addr_q;
endmodule
